// File: rtl/rx_pkg.sv
// Purpose: constants and types shared by the GMII RX FCS checker and the future TX FCS generator.
// Latency: none (package only).
// Backpressure: none (package only).
package rx_pkg;
    localparam int OCT = 8;

    localparam logic [OCT-1:0] PRE = 8'b10101010;
    localparam logic [OCT-1:0] SFD = 8'b10101011;

    // Reflected CRC-32 (IEEE 802.3), processed LSB first.
    localparam logic [31:0] CRC32_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT  = 32'hFFFFFFFF;
    // Register value left over after data followed by its own correct FCS.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Frame length counter width; counts saturate at 2047.
    localparam int LEN_W = 11;
    localparam logic [LEN_W-1:0] MIN_LEN = 11'd64;
    localparam logic [LEN_W-1:0] MAX_LEN = 11'd1518;

    typedef enum logic [1:0] {
        IDLE,
        PRE_S,
        DATA,
        DROP
    } rx_state_t;
endpackage

// File: rtl/rx_gmii_fcs_if.sv
// Purpose: GMII receive pins plus the FCS-stripped byte stream and end-of-frame status.
// Latency: none (wires only).
// Backpressure: none; GMII cannot be stalled, so the stream is valid-only.
// Ports: RX_DV/RXD/RX_ER from the PHY; fcs_data_v/fcs_data byte stream;
//        frame_done strobe with frame_ok, fcs_err, runt_err, long_err, phy_err, frame_len.
interface rx_gmii_fcs_if;
    import rx_pkg::*;

    logic             RX_DV;
    logic [OCT-1:0]   RXD;
    logic             RX_ER;

    logic             fcs_data_v;
    logic [OCT-1:0]   fcs_data;
    logic             frame_done;
    logic             frame_ok;
    logic             fcs_err;
    logic             runt_err;
    logic             long_err;
    logic             phy_err;
    logic [LEN_W-1:0] frame_len;

    // master: the PHY side driving GMII and consuming the stream.
    modport master (
        output RX_DV, RXD, RX_ER,
        input  fcs_data_v, fcs_data, frame_done, frame_ok,
               fcs_err, runt_err, long_err, phy_err, frame_len
    );

    // slave: the FCS checker.
    modport slave (
        input  RX_DV, RXD, RX_ER,
        output fcs_data_v, fcs_data, frame_done, frame_ok,
               fcs_err, runt_err, long_err, phy_err, frame_len
    );
endinterface

// File: rtl/crc32_byte.sv
// Purpose: next CRC-32 register value after one byte, reflected polynomial, LSB first.
// Latency: combinational.
// Backpressure: none.
// Ports: crc_in current register, data byte, crc_out updated register.
module crc32_byte
    import rx_pkg::*;
(
    input  logic [31:0]    crc_in,
    input  logic [OCT-1:0] data,
    output logic [31:0]    crc_out
);
    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < OCT; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end
endmodule

// File: rtl/rx_gmii_fcs.sv
// Purpose: strip preamble/SFD, check FCS, forward frame bytes minus FCS, strobe end-of-frame status.
// Latency: byte i is output the cycle after byte i+4 is sampled; status the cycle after RX_DV drops.
// Backpressure: none; downstream must accept every fcs_data_v byte.
// Ports: RX_CLK, rst (sync, active high), bus (slave side of rx_gmii_fcs_if).
module rx_gmii_fcs
    import rx_pkg::*;
(
    input  logic          RX_CLK,
    input  logic          rst,
    rx_gmii_fcs_if.slave  bus
);
    rx_state_t            state, state_nxt;
    logic                 take;   // a frame byte is being consumed this cycle
    logic                 eof;    // RX_DV dropped while in DATA

    logic [31:0]          crc, crc_nxt;
    logic [LEN_W-1:0]     len;
    logic                 phy;
    // dly[3] is the oldest byte; it leaves once a fifth byte arrives,
    // so the final four bytes (the FCS) are never forwarded.
    logic [3:0][OCT-1:0]  dly;

    logic                 v_q, done_q, ok_q, fcs_q, runt_q, long_q, phy_q;
    logic [OCT-1:0]       d_q;
    logic [LEN_W-1:0]     len_q;
    logic                 fcs_bad, runt, too_long;

    crc32_byte u_crc (
        .crc_in  (crc),
        .data    (bus.RXD),
        .crc_out (crc_nxt)
    );

    assign fcs_bad  = (crc != CRC_RESIDUE);
    assign runt     = (len < MIN_LEN);
    assign too_long = (len > MAX_LEN);

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state <= DROP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        eof       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.RX_DV) begin
                    if (bus.RXD == PRE)      state_nxt = PRE_S;
                    else if (bus.RXD == SFD) state_nxt = DATA;
                    else                     state_nxt = DROP;
                end
            end
            PRE_S: begin
                if (!bus.RX_DV)          state_nxt = IDLE;
                else if (bus.RXD == PRE) state_nxt = PRE_S;
                else if (bus.RXD == SFD) state_nxt = DATA;
                else                     state_nxt = DROP;
            end
            DATA: begin
                if (bus.RX_DV) begin
                    take = 1'b1;
                end else begin
                    eof       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (!bus.RX_DV) state_nxt = IDLE;
            end
            default: state_nxt = DROP;
        endcase
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            crc    <= CRC32_INIT;
            len    <= '0;
            phy    <= 1'b0;
            dly    <= '0;
            v_q    <= 1'b0;
            d_q    <= '0;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            fcs_q  <= 1'b0;
            runt_q <= 1'b0;
            long_q <= 1'b0;
            phy_q  <= 1'b0;
            len_q  <= '0;
        end else begin
            v_q    <= 1'b0;
            done_q <= 1'b0;
            if (take) begin
                crc <= crc_nxt;
                dly <= {dly[2:0], bus.RXD};
                if (len != {LEN_W{1'b1}}) len <= len + 1'b1;
                if (bus.RX_ER) phy <= 1'b1;
                // Output index is len-4; stop after MAX_LEN-4 bytes to bound RX memory use.
                if (len >= 11'd4 && len < MAX_LEN) begin
                    v_q <= 1'b1;
                    d_q <= dly[3];
                end
            end
            if (eof) begin
                done_q <= 1'b1;
                len_q  <= len;
                fcs_q  <= fcs_bad;
                runt_q <= runt;
                long_q <= too_long;
                phy_q  <= phy;
                ok_q   <= !(fcs_bad || runt || too_long || phy);
                crc    <= CRC32_INIT;
                len    <= '0;
                phy    <= 1'b0;
                dly    <= '0;
            end
        end
    end

    assign bus.fcs_data_v = v_q;
    assign bus.fcs_data   = d_q;
    assign bus.frame_done = done_q;
    assign bus.frame_ok   = ok_q;
    assign bus.fcs_err    = fcs_q;
    assign bus.runt_err   = runt_q;
    assign bus.long_err   = long_q;
    assign bus.phy_err    = phy_q;
    assign bus.frame_len  = len_q;
endmodule

// File: tb/tb_rx_gmii_fcs.sv
// Purpose: self-checking bench for rx_gmii_fcs; directed frames followed by random frames.
// Latency: expectations keyed by the RX_CLK edge at which each output must appear.
// Backpressure: none; the bench drives GMII every cycle.
`timescale 1ns/1ps
module tb_rx_gmii_fcs;
    import rx_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef bit         eq_t[$];

    typedef struct {
        int len;
        bit fcs;
        bit runt;
        bit lng;
        bit phy;
    } st_t;

    typedef struct {
        int len;
        bit ok;
        bit fcs;
        bit runt;
        bit lng;
        bit phy;
        int fwd;
    } lit_t;

    logic RX_CLK = 1'b0;
    logic rst;

    rx_gmii_fcs_if bus ();

    rx_gmii_fcs dut (
        .RX_CLK (RX_CLK),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 RX_CLK = ~RX_CLK;

    int cyc = 0;
    always @(posedge RX_CLK) cyc <= cyc + 1;

    // Expectations indexed by the edge number at which they take effect.
    bit         exp_v   [int];
    logic [7:0] exp_d   [int];
    st_t        exp_st  [int];
    bit         exp_rst [int];
    lit_t       lit     [int];

    int total    = 0;
    int bad      = 0;
    int held_len = 0;
    int fwd_cnt  = 0;

    // Standard Ethernet CRC-32 (with final inversion) over the first n bytes.
    function automatic logic [31:0] crc32_of(input bq_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB88320;
                else                c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic logic [31:0] crc_check_value();
        bq_t q;
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        return crc32_of(q, 9);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge RX_CLK) begin
        st_t  st;
        lit_t l;
        if (cyc == 1) chk("crc_model_pin", crc_check_value(), 32'hCBF43926);
        if (cyc > 0) begin
            if (bus.fcs_data_v) fwd_cnt++;
            if (exp_rst.exists(cyc)) begin
                chk("rst_data_v", 32'(bus.fcs_data_v), 32'd0);
                chk("rst_data",   32'(bus.fcs_data),   32'd0);
                chk("rst_done",   32'(bus.frame_done), 32'd0);
                chk("rst_flags",  32'({bus.frame_ok, bus.fcs_err, bus.runt_err,
                                       bus.long_err, bus.phy_err}), 32'd0);
                chk("rst_len",    32'(bus.frame_len),  32'd0);
                held_len = 0;
                fwd_cnt  = 0;
            end else begin
                chk("data_v", 32'(bus.fcs_data_v), 32'(exp_v.exists(cyc)));
                if (exp_v.exists(cyc))
                    chk("data", 32'(bus.fcs_data), 32'(exp_d[cyc]));
                chk("frame_done", 32'(bus.frame_done), 32'(exp_st.exists(cyc)));
                if (exp_st.exists(cyc)) begin
                    st = exp_st[cyc];
                    chk("frame_len", 32'(bus.frame_len), 32'(st.len));
                    chk("fcs_err",   32'(bus.fcs_err),   32'(st.fcs));
                    chk("runt_err",  32'(bus.runt_err),  32'(st.runt));
                    chk("long_err",  32'(bus.long_err),  32'(st.lng));
                    chk("phy_err",   32'(bus.phy_err),   32'(st.phy));
                    chk("frame_ok",  32'(bus.frame_ok),
                        32'(!(st.fcs || st.runt || st.lng || st.phy)));
                    held_len = st.len;
                    if (lit.exists(cyc)) begin
                        l = lit[cyc];
                        chk("lit_len",  32'(bus.frame_len), 32'(l.len));
                        chk("lit_ok",   32'(bus.frame_ok),  32'(l.ok));
                        chk("lit_fcs",  32'(bus.fcs_err),   32'(l.fcs));
                        chk("lit_runt", 32'(bus.runt_err),  32'(l.runt));
                        chk("lit_long", 32'(bus.long_err),  32'(l.lng));
                        chk("lit_phy",  32'(bus.phy_err),   32'(l.phy));
                        chk("lit_fwd",  32'(fwd_cnt),       32'(l.fwd));
                    end
                    fwd_cnt = 0;
                end
                chk("len_hold", 32'(bus.frame_len), 32'(held_len));
            end
        end
    end

    task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit e, output int eo);
        @(posedge RX_CLK);
        #1;
        rst        = r;
        bus.RX_DV  = v;
        bus.RXD    = d;
        bus.RX_ER  = e;
        eo = cyc + 1;
        if (r) exp_rst[eo] = 1'b1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, e);
    endtask

    // Sends preamble, SFD, frame bytes and the terminating RX_DV=0 cycle,
    // recording what the outputs must show. rst_at >= 0 pulses rst on that byte.
    task automatic send_frame(input int npre, input bq_t b, input eq_t ers,
                              input int rst_at, output int done_e);
        int  e;
        int  n;
        bit  dropped;
        bit  anyer;
        st_t st;
        logic [31:0] c;
        n = b.size();
        dropped = 1'b0;
        anyer   = 1'b0;
        for (int p = 0; p < npre; p++)
            drive(1'b0, 1'b1, PRE, ($urandom_range(0, 3) == 0), e);
        drive(1'b0, 1'b1, SFD, 1'b0, e);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                drive(1'b1, 1'b1, b[i], 1'b0, e);
                dropped = 1'b1;
            end else begin
                drive(1'b0, 1'b1, b[i], ers[i], e);
                if (ers[i]) anyer = 1'b1;
                if (!dropped && i >= 4 && (i - 4) < (int'(MAX_LEN) - 4)) begin
                    exp_v[e] = 1'b1;
                    exp_d[e] = b[i - 4];
                end
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, e);
        if (dropped) begin
            done_e = -1;
        end else begin
            st.len  = (n > 2047) ? 2047 : n;
            st.runt = (st.len < 64);
            st.lng  = (st.len > 1518);
            st.phy  = anyer;
            if (n < 4) begin
                st.fcs = 1'b1;
            end else begin
                c = crc32_of(b, n - 4);
                st.fcs = (c != {b[n-1], b[n-2], b[n-3], b[n-4]});
            end
            exp_st[e] = st;
            done_e = e;
        end
    endtask

    task automatic send_raw(input bq_t b);
        int e;
        foreach (b[i]) drive(1'b0, 1'b1, b[i], 1'b0, e);
        drive(1'b0, 1'b0, 8'h00, 1'b0, e);
    endtask

    task automatic make_good(input bq_t p, output bq_t f);
        logic [31:0] c;
        f = p;
        c = crc32_of(p, p.size());
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        f.push_back(c[23:16]);
        f.push_back(c[31:24]);
    endtask

    task automatic zeros(input int n, output eq_t q);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(1'b0);
    endtask

    initial begin
        bq_t  pay, fr, seq64, raw;
        eq_t  ers;
        int   de, n, kind, pos;
        lit_t good64;
        logic [7:0] rb;

        good64 = '{len: 64, ok: 1'b1, fcs: 1'b0, runt: 1'b0, lng: 1'b0, phy: 1'b0, fwd: 60};

        rst       = 1'b1;
        bus.RX_DV = 1'b0;
        bus.RXD   = 8'h00;
        bus.RX_ER = 1'b0;
        exp_rst[1] = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b0, de);
        idle(3);

        // 64-byte good frame, 0x00..0x3B payload, long preamble.
        pay = {};
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        make_good(pay, seq64);
        zeros(64, ers);
        send_frame(7, seq64, ers, -1, de);
        lit[de] = good64;
        idle(2);

        // "123456789" with its known FCS: short frame, CRC correct.
        fr = {};
        for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
        fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
        zeros(13, ers);
        send_frame(1, fr, ers, -1, de);
        lit[de] = '{len: 13, ok: 1'b0, fcs: 1'b0, runt: 1'b1, lng: 1'b0, phy: 1'b0, fwd: 9};
        idle(1);

        // Payload byte 10 corrupted.
        fr = seq64;
        fr[10] = fr[10] ^ 8'h04;
        zeros(64, ers);
        send_frame(7, fr, ers, -1, de);
        lit[de] = '{len: 64, ok: 1'b0, fcs: 1'b1, runt: 1'b0, lng: 1'b0, phy: 1'b0, fwd: 60};
        idle(1);

        // 1600-byte frame: forwarding capped, counting continues.
        pay = {};
        for (int i = 0; i < 1596; i++) pay.push_back(8'($urandom));
        make_good(pay, fr);
        zeros(1600, ers);
        send_frame(7, fr, ers, -1, de);
        lit[de] = '{len: 1600, ok: 1'b0, fcs: 1'b0, runt: 1'b0, lng: 1'b1, phy: 1'b0, fwd: 1514};
        idle(2);

        // RX_ER for one cycle mid-frame.
        zeros(64, ers);
        ers[30] = 1'b1;
        send_frame(7, seq64, ers, -1, de);
        lit[de] = '{len: 64, ok: 1'b0, fcs: 1'b0, runt: 1'b0, lng: 1'b0, phy: 1'b1, fwd: 60};
        idle(1);

        // Bad start sequence, then a good frame.
        raw = {};
        raw.push_back(PRE); raw.push_back(PRE); raw.push_back(8'h12);
        raw.push_back(8'h34); raw.push_back(SFD); raw.push_back(8'h56);
        send_raw(raw);
        zeros(64, ers);
        send_frame(7, seq64, ers, -1, de);
        lit[de] = good64;
        idle(1);

        // Reset on byte 20 of a frame, then a good frame.
        zeros(64, ers);
        send_frame(7, seq64, ers, 20, de);
        idle(1);
        send_frame(7, seq64, ers, -1, de);
        lit[de] = good64;
        idle(1);

        // SFD without preamble.
        send_frame(0, seq64, ers, -1, de);
        lit[de] = good64;

        // Random traffic.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(4, 8);
                fr = {};
                for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
                zeros(n, ers);
                send_frame($urandom_range(0, 7), fr, ers, -1, de);
            end else if (kind == 9) begin
                raw = {};
                for (int i = 0; i < $urandom_range(0, 3); i++) raw.push_back(PRE);
                rb = 8'($urandom);
                if (rb == PRE || rb == SFD) rb = 8'h12;
                raw.push_back(rb);
                for (int i = 0; i < $urandom_range(0, 6); i++) raw.push_back(8'($urandom));
                send_raw(raw);
            end else begin
                pay = {};
                n = $urandom_range(1, 126);
                for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
                make_good(pay, fr);
                if ($urandom_range(0, 3) == 0) begin
                    pos = $urandom_range(0, fr.size() - 1);
                    fr[pos] = fr[pos] ^ (8'h01 << $urandom_range(0, 7));
                end
                zeros(fr.size(), ers);
                if ($urandom_range(0, 5) == 0) ers[$urandom_range(0, fr.size() - 1)] = 1'b1;
                send_frame($urandom_range(0, 7), fr, ers, -1, de);
            end
            idle($urandom_range(0, 2));
        end

        idle(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
